// File: rtl/sdi_trs_decoder.sv
// sdi_trs_decoder: receive-side TRS decoder for the SDI word stream.
// Finds 3FF/000/000/XYZ, validates the XYZ protection bits and extracts F/V/H.
// Measures line length (EAV to EAV) and line count, and reports lock.
// Forwards the word stream with one cycle of latency, with EAV/SAV/error
// strobes aligned to the XYZ word on video_out.
module sdi_trs_decoder #(
  parameter int SAMPLE_W   = 12,
  parameter int LINE_W     = 11,
  parameter int LOCK_COUNT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          rx_data,
  input  logic                rx_data_valid,
  output logic [9:0]          video_out,
  output logic                video_out_valid,
  output logic                trs_eav,
  output logic                trs_sav,
  output logic                xyz_err,
  output logic                f_bit,
  output logic                v_bit,
  output logic                h_bit,
  output logic [SAMPLE_W-1:0] line_len,
  output logic [LINE_W-1:0]   line_cnt,
  output logic                locked
);

  localparam int CTR_W = $clog2(LOCK_COUNT + 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = '1;
  localparam logic [LINE_W-1:0]   LINE_MAX   = '1;
  localparam logic [CTR_W-1:0]    LOCK_TOP   = CTR_W'(LOCK_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_3FF, S_Z1, S_Z2} state_t;

  state_t              state, state_next;
  logic [SAMPLE_W-1:0] sample_cnt;
  logic [SAMPLE_W-1:0] len;
  logic [CTR_W-1:0]    lock_ctr;
  logic                meas_valid;
  logic                ref_valid;
  logic                prev_eav_v;
  logic                xyz_word, xyz_ok, good_eav, good_sav, bad_xyz;
  logic                w_f, w_v, w_h;

  assign w_f = rx_data[8];
  assign w_v = rx_data[7];
  assign w_h = rx_data[6];

  // The word arriving in S_Z2 is the XYZ word; check its protection bits.
  assign xyz_word = rx_data_valid && (state == S_Z2);
  assign xyz_ok   = rx_data[9]
                 && (rx_data[5] == (w_v ^ w_h))
                 && (rx_data[4] == (w_f ^ w_h))
                 && (rx_data[3] == (w_f ^ w_v))
                 && (rx_data[2] == (w_f ^ w_v ^ w_h))
                 && (rx_data[1:0] == 2'b00);
  assign good_eav = xyz_word && xyz_ok && w_h;
  assign good_sav = xyz_word && xyz_ok && !w_h;
  assign bad_xyz  = xyz_word && !xyz_ok;

  // Length of the line that ends with the current EAV word.
  assign len = sample_cnt + SAMPLE_W'(1);

  // State register; only valid words advance the matcher.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
    if (reset)              state <= S_IDLE;
    else if (rx_data_valid) state <= state_next;
  end

  // Next-state table for the 3FF/000/000/XYZ matcher.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of inferred latches.
    state_next = state;
    unique case (state)
      S_IDLE: state_next = (rx_data == 10'h3FF) ? S_3FF : S_IDLE;
      S_3FF: begin
        if (rx_data == 10'h000)      state_next = S_Z1;
        else if (rx_data == 10'h3FF) state_next = S_3FF;
        else                         state_next = S_IDLE;
      end
      S_Z1: begin
        if (rx_data == 10'h000)      state_next = S_Z2;
        else if (rx_data == 10'h3FF) state_next = S_3FF;
        else                         state_next = S_IDLE;
      end
      S_Z2:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output pipeline stage: forwarded word plus strobes aligned with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      video_out       <= '0;
      video_out_valid <= 1'b0;
      trs_eav         <= 1'b0;
      trs_sav         <= 1'b0;
      xyz_err         <= 1'b0;
    end else begin
      if (rx_data_valid) video_out <= rx_data;
      video_out_valid <= rx_data_valid;
      trs_eav         <= good_eav;
      trs_sav         <= good_sav;
      xyz_err         <= bad_xyz;
    end
  end

  // Hold the flags of the most recent XYZ word that passed its checks.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_bit <= 1'b0;
      v_bit <= 1'b0;
      h_bit <= 1'b0;
    end else if (good_eav || good_sav) begin
      f_bit <= w_f;
      v_bit <= w_v;
      h_bit <= w_h;
    end
  end

  // Line length measurement and lock tracking, driven by good EAVs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt <= '0;
      meas_valid <= 1'b0;
      ref_valid  <= 1'b0;
      line_len   <= '0;
      lock_ctr   <= '0;
      locked     <= 1'b0;
    end else if (good_eav) begin
      sample_cnt <= '0;
      if (!meas_valid) begin
        // First EAV after start-up or saturation only opens a measurement window.
        meas_valid <= 1'b1;
      end else if (!ref_valid) begin
        line_len  <= len;
        ref_valid <= 1'b1;
        lock_ctr  <= '0;
      end else if (len == line_len) begin
        if (lock_ctr != LOCK_TOP) lock_ctr <= lock_ctr + CTR_W'(1);
        if (lock_ctr >= LOCK_TOP - CTR_W'(1)) locked <= 1'b1;
      end else begin
        line_len <= len;
        lock_ctr <= '0;
        locked   <= 1'b0;
      end
    end else if (rx_data_valid) begin
      if (sample_cnt != SAMPLE_MAX) sample_cnt <= sample_cnt + SAMPLE_W'(1);
      // Reaching the ceiling means the line is longer than can be measured.
      if (sample_cnt >= SAMPLE_MAX - SAMPLE_W'(1)) begin
        meas_valid <= 1'b0;
        lock_ctr   <= '0;
        locked     <= 1'b0;
      end
      if (bad_xyz) begin
        lock_ctr <= '0;
        locked   <= 1'b0;
      end
    end
  end

  // Line counter: restarts on the first EAV of vertical blanking.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt   <= '0;
      prev_eav_v <= 1'b0;
    end else if (good_eav) begin
      if (w_v && !prev_eav_v)      line_cnt <= '0;
      else if (line_cnt != LINE_MAX) line_cnt <= line_cnt + LINE_W'(1);
      prev_eav_v <= w_v;
    end
  end

endmodule
